// File: rtl/br_resolve_queue.sv
// br_resolve_queue
//   In-order queue of in-flight branches sitting between fetch (which records
//   each prediction it issues) and execute (which resolves the oldest one).
//   On every resolution it drives the branch predictor's update port and, on a
//   mispredict, a one-cycle flush/redirect to fetch. It also keeps saturating
//   performance counters and sticky under/overflow flags.
//
// Ports
//   CLK, nRST                    clock, asynchronous active-low reset
//   f_push/f_index/f_predict/    fetch-side record of an issued branch
//   f_pred_target/f_pc_plus4
//   f_full                       combinational: queue holds DEPTH entries
//   ex_valid/ex_taken/ex_target  execute-side resolution of the oldest branch
//   upd_br/upd_taken/            registered predictor update (1-cycle latency)
//   upd_index/upd_target
//   mispredict/redirect_pc       registered flush pulse and correct next PC
//   count                        current occupancy
//   br_cnt/mp_cnt                saturating resolved / mispredicted counters
//   err                          sticky [0] underflow, [1] overflow
module br_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       f_push,
  input  logic [IDX_W-1:0]           f_index,
  input  logic                       f_predict,
  input  logic [WORD_W-1:0]          f_pred_target,
  input  logic [WORD_W-1:0]          f_pc_plus4,
  output logic                       f_full,
  input  logic                       ex_valid,
  input  logic                       ex_taken,
  input  logic [WORD_W-1:0]          ex_target,
  output logic                       upd_br,
  output logic                       upd_taken,
  output logic [IDX_W-1:0]           upd_index,
  output logic [WORD_W-1:0]          upd_target,
  output logic                       mispredict,
  output logic [WORD_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                br_cnt,
  output logic [15:0]                mp_cnt,
  output logic [1:0]                 err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic              predict;
    logic [WORD_W-1:0] pred_target;
    logic [WORD_W-1:0] pc_plus4;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail;

  // Resolution-side decode
  entry_t          head_e;
  logic            is_empty, is_full;
  logic            pop, wrong, push_ok, overflow, underflow;
  logic [WORD_W-1:0] corr_pc, new_target;

  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));
  assign f_full   = is_full;

  assign head_e   = mem[head];
  assign pop      = ex_valid && !is_empty;
  assign underflow = ex_valid && is_empty;

  // A taken prediction to the wrong target is as wrong as a wrong direction.
  assign wrong = pop &&
                 ((head_e.predict != ex_taken) ||
                  (head_e.predict && ex_taken && (head_e.pred_target != ex_target)));

  assign corr_pc    = ex_taken ? ex_target : head_e.pc_plus4;
  // Not-taken resolutions leave the predictor's stored target untouched.
  assign new_target = ex_taken ? ex_target : head_e.pred_target;

  // A push accepted on the same edge as a mispredicted pop is on the wrong
  // path; it is squashed silently (not an overflow).
  assign push_ok  = f_push && (!is_full || pop) && !wrong;
  assign overflow = f_push && is_full && !pop;

  // Entry storage: no reset needed, occupancy tracks validity.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[tail] <= '{index:       f_index,
                     predict:     f_predict,
                     pred_target: f_pred_target,
                     pc_plus4:    f_pc_plus4};
    end
  end

  // Pointers and occupancy
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (wrong) begin
      // Flush everything younger than the mispredicted branch.
      head  <= tail;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered predictor update / redirect outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      upd_br      <= 1'b0;
      upd_taken   <= 1'b0;
      upd_index   <= '0;
      upd_target  <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_br     <= pop;
      mispredict <= wrong;
      if (pop) begin
        upd_taken  <= ex_taken;
        upd_index  <= head_e.index;
        upd_target <= new_target;
      end
      if (wrong) redirect_pc <= corr_pc;
    end
  end

  // Saturating stats and sticky error flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_cnt <= '0;
      mp_cnt <= '0;
      err    <= '0;
    end else begin
      if (pop   && (br_cnt != 16'hFFFF)) br_cnt <= br_cnt + 16'd1;
      if (wrong && (mp_cnt != 16'hFFFF)) mp_cnt <= mp_cnt + 16'd1;
      if (underflow) err[0] <= 1'b1;
      if (overflow)  err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed bench for br_resolve_queue. Each resolution pushes its expected
// predictor update into a scoreboard; a negedge monitor pops and compares
// whenever upd_br is seen. Occupancy/counter/error state is checked inline.
module tb_br_resolve_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        f_push;
  logic [1:0]  f_index;
  logic        f_predict;
  logic [31:0] f_pred_target, f_pc_plus4;
  logic        f_full;
  logic        ex_valid, ex_taken;
  logic [31:0] ex_target;
  logic        upd_br, upd_taken;
  logic [1:0]  upd_index;
  logic [31:0] upd_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic [15:0] br_cnt, mp_cnt;
  logic [1:0]  err;

  br_resolve_queue #(.DEPTH(4), .IDX_W(2), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .f_push(f_push), .f_index(f_index), .f_predict(f_predict),
    .f_pred_target(f_pred_target), .f_pc_plus4(f_pc_plus4), .f_full(f_full),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .upd_br(upd_br), .upd_taken(upd_taken), .upd_index(upd_index),
    .upd_target(upd_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .count(count), .br_cnt(br_cnt), .mp_cnt(mp_cnt), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  idx;
    logic        taken;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_br = '0;
  logic [15:0] exp_mp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every update pulse against the oldest expectation.
  always @(negedge CLK) begin
    if (upd_br === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_upd_br: got idx %0d, expected no pulse @%0t", upd_index, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd_index",  32'(upd_index),  32'(e.idx));
        chk("upd_taken",  32'(upd_taken),  32'(e.taken));
        chk("upd_target", upd_target,      e.tgt);
        chk("mispredict", 32'(mispredict), 32'(e.mp));
        if (e.mp) chk("redirect_pc", redirect_pc, e.rpc);
      end
    end else if (mispredict !== 1'b0) begin
      checks++; errors++;
      $display("FAIL stray_mispredict: got %b, expected 0 @%0t", mispredict, $time);
    end
  end

  task automatic expect_upd(input logic [1:0] idx, input logic tk, input logic [31:0] tgt,
                            input logic mp, input logic [31:0] rpc);
    exp_t e;
    e.idx = idx; e.taken = tk; e.tgt = tgt; e.mp = mp; e.rpc = rpc;
    sb.push_back(e);
    if (exp_br != 16'hFFFF) exp_br++;
    if (mp && exp_mp != 16'hFFFF) exp_mp++;
  endtask

  // Apply one cycle of stimulus from a negedge; returns at the next negedge.
  task automatic drive(input logic p, input logic [1:0] idx, input logic pr,
                       input logic [31:0] pt, input logic [31:0] p4,
                       input logic v, input logic tk, input logic [31:0] et);
    f_push = p; f_index = idx; f_predict = pr; f_pred_target = pt; f_pc_plus4 = p4;
    ex_valid = v; ex_taken = tk; ex_target = et;
    @(negedge CLK);
    f_push = 1'b0; ex_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] idx, input logic pr, input logic [31:0] pt, input logic [31:0] p4);
    drive(1'b1, idx, pr, pt, p4, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pop(input logic tk, input logic [31:0] et);
    drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, tk, et);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_br_cnt"}, 32'(br_cnt), 32'(exp_br));
    chk({tag, "_mp_cnt"}, 32'(mp_cnt), 32'(exp_mp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    f_push = 0; f_index = 0; f_predict = 0; f_pred_target = 0; f_pc_plus4 = 0;
    ex_valid = 0; ex_taken = 0; ex_target = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_f_full", 32'(f_full), 0);
    chk("rst_upd_br", 32'(upd_br), 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_err", 32'(err), 0);
    chk_stats("rst");

    // Predicted not-taken, actually taken -> redirect to target
    push(2'd1, 1'b0, 32'h0, 32'h104);
    expect_upd(2'd1, 1'b1, 32'h200, 1'b1, 32'h200);
    pop(1'b1, 32'h200);
    chk("t1_count", 32'(count), 0);
    chk_stats("t1");

    // Fill, overflow, drain in order with correct predictions
    for (int i = 0; i < 4; i++)
      push(2'(i), (i != 2), 32'h1000 + 32'(16*i), 32'h2000 + 32'(16*i));
    chk("t2_count_full", 32'(count), 4);
    chk("t2_f_full", 32'(f_full), 1);
    chk("t2_err_before", 32'(err), 0);
    push(2'd0, 1'b1, 32'h1100, 32'h2100);
    chk("t2_count_after_ovf", 32'(count), 4);
    chk("t2_err_ovf", 32'(err), 2);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        expect_upd(2'd2, 1'b0, 32'h1020, 1'b0, 32'h0);
        pop(1'b0, 32'h1234);
      end else begin
        expect_upd(2'(i), 1'b1, 32'h1000 + 32'(16*i), 1'b0, 32'h0);
        pop(1'b1, 32'h1000 + 32'(16*i));
      end
    end
    chk("t2_count_empty", 32'(count), 0);
    chk("t2_f_full_clr", 32'(f_full), 0);
    chk_stats("t2");

    // Taken with wrong target flushes queue and the same-edge push
    push(2'd1, 1'b1, 32'h300, 32'h104);
    push(2'd2, 1'b0, 32'h310, 32'h108);
    push(2'd3, 1'b1, 32'h320, 32'h10C);
    chk("t3_count3", 32'(count), 3);
    expect_upd(2'd1, 1'b1, 32'h340, 1'b1, 32'h340);
    drive(1'b1, 2'd0, 1'b1, 32'h330, 32'h110, 1'b1, 1'b1, 32'h340);
    chk("t3_count_flush", 32'(count), 0);
    chk("t3_err_noovf", 32'(err), 2);
    chk_stats("t3");

    // Not-taken/not-taken keeps stored target; redirect_pc holds
    push(2'd2, 1'b0, 32'h500, 32'h604);
    expect_upd(2'd2, 1'b0, 32'h500, 1'b0, 32'h0);
    pop(1'b0, 32'h999);
    chk("t4_redirect_hold", redirect_pc, 32'h340);
    chk("t4_count", 32'(count), 0);

    // Simultaneous push+pop preserves order; taken-predicted, not-taken actual
    push(2'd0, 1'b0, 32'h20, 32'h10);
    expect_upd(2'd0, 1'b0, 32'h20, 1'b0, 32'h0);
    drive(1'b1, 2'd1, 1'b0, 32'h30, 32'h14, 1'b1, 1'b0, 32'h77);
    chk("t5_count_pp", 32'(count), 1);
    expect_upd(2'd1, 1'b1, 32'h44, 1'b1, 32'h44);
    pop(1'b1, 32'h44);
    push(2'd2, 1'b1, 32'h80, 32'h64);
    expect_upd(2'd2, 1'b0, 32'h80, 1'b1, 32'h64);
    pop(1'b0, 32'h80);
    chk("t5_redirect_fallthru", redirect_pc, 32'h64);
    chk_stats("t5");

    // Underflow with simultaneous push
    drive(1'b1, 2'd3, 1'b1, 32'h700, 32'h804, 1'b1, 1'b0, 32'h0);
    chk("t6_err_unf", 32'(err), 3);
    chk("t6_count", 32'(count), 1);
    chk_stats("t6");
    expect_upd(2'd3, 1'b1, 32'h700, 1'b0, 32'h0);
    pop(1'b1, 32'h700);
    chk("t6_count_empty", 32'(count), 0);

    // br_cnt saturation
    force dut.br_cnt = 16'hFFFE;
    #1 release dut.br_cnt;
    exp_br = 16'hFFFE;
    push(2'd0, 1'b0, 32'h10, 32'h4);
    expect_upd(2'd0, 1'b0, 32'h10, 1'b0, 32'h0);
    drive(1'b1, 2'd1, 1'b0, 32'h14, 32'h8, 1'b1, 1'b0, 32'h0);
    expect_upd(2'd1, 1'b0, 32'h14, 1'b0, 32'h0);
    drive(1'b1, 2'd2, 1'b0, 32'h18, 32'hC, 1'b1, 1'b0, 32'h0);
    expect_upd(2'd2, 1'b0, 32'h18, 1'b0, 32'h0);
    pop(1'b0, 32'h0);
    chk("t7_br_sat", 32'(br_cnt), 32'hFFFF);
    chk_stats("t7");

    // Async reset with two entries queued
    push(2'd1, 1'b1, 32'h900, 32'hA04);
    push(2'd2, 1'b0, 32'h910, 32'hA08);
    chk("t8_count2", 32'(count), 2);
    #2 nRST = 1'b0;
    #1;
    chk("t8_count", 32'(count), 0);
    chk("t8_f_full", 32'(f_full), 0);
    chk("t8_upd_br", 32'(upd_br), 0);
    chk("t8_upd_taken", 32'(upd_taken), 0);
    chk("t8_upd_index", 32'(upd_index), 0);
    chk("t8_upd_target", upd_target, 0);
    chk("t8_mispredict", 32'(mispredict), 0);
    chk("t8_redirect", redirect_pc, 0);
    chk("t8_err", 32'(err), 0);
    exp_br = '0; exp_mp = '0;
    chk_stats("t8");
    ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h900;
    @(negedge CLK);
    ex_valid = 1'b0;
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t8_count_after", 32'(count), 0);
    chk_stats("t8_after");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_resolve_queue.md
Name: br_resolve_queue

Overview:
- Consumer-side counterpart to the 4-entry 2-bit branch predictor. It records each prediction issued at fetch in an in-order queue of in-flight branches.
- At execute it pops the oldest entry and compares the prediction against the actual outcome. It then drives the predictor's update port (br, br_taken, index_update, br_target_I) and a redirect/flush to fetch on mispredict.
- It also keeps saturating branch and mispredict counters for performance stats.

Parameters:
DEPTH, 4, number of in-flight branch entries (power of 2, >= 2)
IDX_W, 2, predictor index width
WORD_W, 32, PC/target width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
f_push  in  1  fetch issued a branch; record the entry
f_index  in  IDX_W  predictor index used at fetch (index_O)
f_predict  in  1  prediction returned at fetch
f_pred_target  in  WORD_W  predicted target (br_target_O)
f_pc_plus4  in  WORD_W  fall-through PC of the branch
f_full  out  1  queue full; fetch must stall branch issue
ex_valid  in  1  execute resolved the oldest branch this cycle
ex_taken  in  1  actual direction
ex_target  in  WORD_W  actual taken target
upd_br  out  1  predictor update strobe (to br)
upd_taken  out  1  to br_taken
upd_index  out  IDX_W  to index_update
upd_target  out  WORD_W  to br_target_I
mispredict  out  1  one-cycle flush/redirect pulse
redirect_pc  out  WORD_W  correct next PC when mispredict=1
count  out  $clog2(DEPTH)+1  current occupancy
br_cnt  out  16  resolved branches, saturating
mp_cnt  out  16  mispredicts, saturating
err  out  2  sticky errors: [0] underflow, [1] overflow

Behaviour:
- Reset (nRST low, async): queue empty, head/tail pointers 0, count=0, f_full=0, upd_br=0, upd_taken=0, upd_index=0, upd_target=0, mispredict=0, redirect_pc=0, br_cnt=0, mp_cnt=0, err=0.
- Reset mid-operation discards all entries immediately. No update or mispredict is emitted for discarded entries.
- Storage: circular buffer of {index, predict, pred_target, pc_plus4}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- f_full is combinational: f_full = (count == DEPTH).
- Push: on a rising edge with f_push=1 and (count<DEPTH, or a pop occurs the same edge), write the entry at tail and increment tail.
- Push while full with no pop: entry dropped, err[1] set.
- Pop: on a rising edge with ex_valid=1 and count>0, read head and increment head.
- ex_valid with count==0 (a same-edge push does not count): no pop, no update, no counter change, err[0] set.
- Resolution of the popped entry e, using ex_* sampled the same edge:
  - wrong = (e.predict != ex_taken) OR (e.predict AND ex_taken AND e.pred_target != ex_target)
  - corr_pc = ex_taken ? ex_target : e.pc_plus4
- Outputs are registered with 1-cycle latency. In the cycle after the pop edge:
  - upd_br=1, upd_taken=ex_taken, upd_index=e.index
  - upd_target = ex_taken ? ex_target : e.pred_target (a not-taken branch keeps its stored target)
  - mispredict=wrong, redirect_pc=corr_pc when wrong (otherwise it holds its previous value)
- upd_br and mispredict are single-cycle pulses. Back-to-back pops give back-to-back pulses.
- Mispredict flush: at the same edge as a wrong pop, all remaining entries are discarded (head=tail, count=0). Any simultaneous push is also discarded, since it is on the wrong path; this sets no error.
- Counters: br_cnt increments on every valid pop; mp_cnt increments on every wrong pop. Both saturate at 16'hFFFF.
- Simultaneous push and pop (correct pop): count unchanged, and the order of entries is preserved.
- err bits clear only on reset.

Test Plan:
- Push idx=1, predict=0, pc_plus4=0x104; then ex_valid, taken=1, target=0x200 -> next cycle: upd_br=1, upd_taken=1, upd_index=1, upd_target=0x200, mispredict=1, redirect_pc=0x200, mp_cnt=1, br_cnt=1.
- Push 4 entries (DEPTH=4) -> f_full=1. A 5th push is dropped and sets err=2'b10. Then pop 4, all correctly predicted -> four consecutive upd_br pulses with indices in push order; mispredict never asserted; count returns to 0.
- Fill to 3; pop the first entry predict=1, pred_target=0x300, actual taken with target 0x340 -> mispredict=1, redirect_pc=0x340. A push on the same edge is discarded and count=0 next cycle.
- Predicted not-taken, actual not-taken, pred_target=0x500 -> upd_target=0x500, mispredict=0.
- ex_valid with the queue empty and a simultaneous push -> no upd_br, err[0]=1, count=1 afterwards.
- Force br_cnt to 0xFFFE and resolve 3 branches -> br_cnt stays at 0xFFFF. Assert nRST mid-stream with 2 entries queued -> all outputs 0 immediately and no pulses follow.
